abr_sample_unpacker: RTL
========================

# abr_sample_unpacker

Read-side counterpart to the sample packing buffer. It accepts fixed-width words of `NUM_IN` samples through a valid/ready handshake and stores them in order in a shift buffer. A downstream consumer then takes a variable, contiguous number of samples per cycle (up to `NUM_OUT`) using a thermometer request mask. It sits between a wide producer (e.g. a memory or hash output word) and a per-sample arithmetic consumer that needs a varying number of samples each cycle.

## Interface
Parameters:
- `NUM_IN`, 4, samples per input word
- `NUM_OUT`, 5, maximum samples popped per cycle
- `DATA_W`, 32, sample width
- `DEPTH`, `NUM_IN+NUM_OUT` (localparam), buffer entries

Ports:
- `clk`  in  1  clock
- `rst_b`  in  1  reset; one clock, synchronous, active-low
- `flush`  in  1  discard all buffered samples
- `data_valid_i`  in  1  input word valid
- `data_i`  in  `[NUM_IN][DATA_W]`  input word; sample 0 is the oldest
- `data_ready_o`  out  1  word accepted when valid & ready
- `req_i`  in  `NUM_OUT`  thermometer pop request (`0`, `0..01`, `0..011`, ...)
- `grant_o`  out  `NUM_OUT`  samples delivered this cycle
- `data_o`  out  `[NUM_OUT][DATA_W]`  head samples; entry 0 is the oldest
- `count_o`  out  `$clog2(DEPTH)+1`  valid entries

## Operation
- State:
  - `buf[DEPTH][DATA_W]`
  - `count`
- Entries `0..count-1` are valid.
- Invalid entries are always zero.
- `data_ready_o = rst_b & ~flush & (DEPTH - count >= NUM_IN)`.
  - Depends on registered `count` only; there is no combinational path from `req_i` to ready.
- `n_req = popcount(req_i)`.
- Grant is all-or-nothing:
  - `grant_o = req_i` when `count >= n_req & ~flush & rst_b`.
  - Otherwise `grant_o = 0`.
- `n_pop = popcount(grant_o)`.
- `wr = data_valid_i & data_ready_o`.
- Next-state update:
  - `buf` shifts right by `n_pop` entries.
  - If `wr`, `data_i` is ORed in at entry `count - n_pop`.
  - `count_next = count - n_pop + (wr ? NUM_IN : 0)`.
  - Vacated upper entries fill with zero.
- `data_o = buf[NUM_OUT-1:0]` and is valid combinationally.
  - Entries at index `>= count` read as zero.
- `count_o = count`.
- Flush:
  - Next cycle `buf = 0` and `count = 0`.
  - Overrides any write and any pop.
  - `grant_o` and `data_ready_o` are 0 during the flush cycle.
- A non-thermometer `req_i` is illegal and is covered by an assertion. No defined response is required.
- Arithmetic:
  - `count` never exceeds `DEPTH`; ready guarantees this.
  - `count - n_pop` is never negative; the grant rule guarantees this.

## Timing
- Reset (`rst_b` low at a `clk` edge):
  - `buf = 0`, `count = 0`.
  - While `rst_b` is low: `grant_o = 0`, `data_ready_o = 0`, `data_o = 0`, `count_o = 0`.
- Reset mid-operation discards all buffered samples. The first cycle after release has `data_ready_o = 1` and `count_o = 0`.
- Write-to-read latency is 1 cycle: a word accepted at edge N appears on `data_o` after edge N.
- There is no bypass from `data_i` to `data_o`.
- Simultaneous pop and write in one cycle is legal. Remaining old samples stay ahead of the new word.
- Full: with `count > DEPTH - NUM_IN`, ready is low. It rises the cycle after a pop brings `count` to `<= DEPTH - NUM_IN`.
- Empty: `count = 0` with any nonzero `req_i` gives `grant_o = 0`.
  - This holds even if a word is being written in the same cycle.
- `grant_o` is combinational from `req_i` and `count`. Consumers sample `data_o` in the same cycle in which `grant_o` is high.

## Structure
- Shared package `abr_params_pkg` (append to it):
  - `popcount`/thermometer-check function
  - `ABR_UNPACK_NUM_IN` / `ABR_UNPACK_NUM_OUT` defaults
- Sub-module `abr_sample_shifter`:
  - Combinational right-shift by `n_pop` plus insert at offset, over `DEPTH` entries.
  - Reusable by the packing side.
- Top level holds the registers, the count logic, ready/grant and the assertions:
  - thermometer `req_i`
  - `count <= DEPTH`
  - `data_i` stable while `valid & ~ready`

## Test plan
Defaults `NUM_IN=4`, `NUM_OUT=5`, `DATA_W=32`.
1. Reset, then write `{4,3,2,1}` (index0 = 1) → next cycle `count_o = 4`, `data_o = {0,4,3,2,1}`, `data_ready_o = 1`.
2. Two writes (`1..8`) → `count_o = 8`, ready 0. Then `req_i = 5'b11111` → `grant_o = 5'b11111`, `data_o = 1..5`; next `count_o = 3`, ready 1.
3. `count = 3`, `req_i = 5'b01111` → `grant_o = 0`, count unchanged. `req_i = 5'b00111` → grant `5'b00111`, count 0.
4. `count = 3` (A,B,C), `req_i = 5'b00011` plus write `{W3,W2,W1,W0}` → grant `5'b00011`, data A,B; next `count = 5`, `data_o = {W3,W2,W1,W0,C}`.
5. `count = 6`, `flush` with `data_valid_i = 1` and `req_i = 5'b00001` → `grant_o = 0`, ready 0; next `count = 0`, `data_o = 0`, ready 1.
6. `count = 6`, `rst_b` low 1 cycle with a valid write → ready and grant 0 during reset; after release `count_o = 0`, `data_o = 0`.

Source files
------------

// File: rtl/abr_params_pkg.sv
`default_nettype none
// ============================================================================
// Module   : abr_params_pkg
// Purpose  : Shared ABR parameters and small helper functions.
//            Holds the sample unpacker defaults and the request-mask
//            popcount / thermometer check used by the unpacker.
// Revision : 1.0 - initial unpacker additions
// ============================================================================
package abr_params_pkg;

    // Sample unpacker defaults
    localparam int ABR_UNPACK_NUM_IN  = 4;
    localparam int ABR_UNPACK_NUM_OUT = 5;

    // Request masks are zero-extended to this width before the helpers
    // below, so one function body serves any NUM_OUT up to 32.
    localparam int ABR_MASK_W = 32;

    // Number of set bits in a request/grant mask.
    function automatic int unsigned abr_popcount(input logic [ABR_MASK_W-1:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < ABR_MASK_W; i++) begin
            n = n + {31'd0, mask[i]};
        end
        return n;
    endfunction

    // True for 0, 0..01, 0..011, ...: adding one to a thermometer code
    // yields a single bit that shares no position with the original.
    function automatic logic abr_is_thermometer(input logic [ABR_MASK_W-1:0] mask);
        return ((mask & (mask + 32'd1)) == '0);
    endfunction

endpackage : abr_params_pkg
`default_nettype wire

// File: rtl/abr_sample_shifter.sv
`default_nettype none
// ============================================================================
// Module   : abr_sample_shifter
// Purpose  : Combinational sample buffer shifter. Shifts a DEPTH-entry buffer
//            toward entry 0 by i_shift entries (vacated top entries become
//            zero), then ORs an NUM_INS-sample word in at i_ins_offset.
//            Reusable by both packing and unpacking sides.
// Ports    : i_buf        current buffer contents, entry 0 oldest
//            i_shift      number of entries removed from the head
//            i_ins_en     insert i_ins_data this cycle
//            i_ins_offset entry index receiving i_ins_data[0]
//            i_ins_data   word to insert, sample 0 oldest
//            o_buf        resulting buffer contents
// Revision : 1.0 - initial release
// ============================================================================
module abr_sample_shifter #(
    parameter int DEPTH   = 9,
    parameter int NUM_INS = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH-1:0][DATA_W-1:0]   i_buf,
    input  logic [CNT_W-1:0]               i_shift,
    input  logic                           i_ins_en,
    input  logic [CNT_W-1:0]               i_ins_offset,
    input  logic [NUM_INS-1:0][DATA_W-1:0] i_ins_data,
    output logic [DEPTH-1:0][DATA_W-1:0]   o_buf
);

    // Written as explicit compare-and-select so no index ever runs off the
    // end of the buffer; out-of-range shifts/offsets simply contribute zero.
    always_comb begin
        o_buf = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < DEPTH - i; s++) begin
                if (i_shift == CNT_W'(s)) begin
                    o_buf[i] = i_buf[i + s];
                end
            end
            // Target entries are zero after the shift, so OR acts as insert.
            for (int j = 0; j < NUM_INS; j++) begin
                if ((j <= i) && i_ins_en && (i_ins_offset == CNT_W'(i - j))) begin
                    o_buf[i] = o_buf[i] | i_ins_data[j];
                end
            end
        end
    end

endmodule : abr_sample_shifter
`default_nettype wire

// File: rtl/abr_sample_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : abr_sample_unpacker
// Purpose  : Accepts NUM_IN-sample words over valid/ready and hands out a
//            variable, contiguous number (0..NUM_OUT) of the oldest samples
//            per cycle against a thermometer request mask. Grants are
//            all-or-nothing.
// Ports    : clk, rst_b      clock, synchronous active-low reset
//            flush           discard all buffered samples
//            data_valid_i    input word valid
//            data_i          input word, sample 0 oldest
//            data_ready_o    word accepted when valid & ready
//            req_i           thermometer pop request
//            grant_o         samples delivered this cycle
//            data_o          head samples, entry 0 oldest
//            count_o         number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module abr_sample_unpacker
    import abr_params_pkg::*;
#(
    parameter int NUM_IN  = ABR_UNPACK_NUM_IN,
    parameter int NUM_OUT = ABR_UNPACK_NUM_OUT,
    parameter int DATA_W  = 32
) (
    input  logic                                clk,
    input  logic                                rst_b,
    input  logic                                flush,
    input  logic                                data_valid_i,
    input  logic [NUM_IN-1:0][DATA_W-1:0]       data_i,
    output logic                                data_ready_o,
    input  logic [NUM_OUT-1:0]                  req_i,
    output logic [NUM_OUT-1:0]                  grant_o,
    output logic [NUM_OUT-1:0][DATA_W-1:0]      data_o,
    output logic [$clog2(NUM_IN+NUM_OUT):0]     count_o
);

    localparam int DEPTH = NUM_IN + NUM_OUT;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] C_WR_LIMIT = CNT_W'(DEPTH - NUM_IN);
    localparam logic [CNT_W-1:0] C_NUM_IN   = CNT_W'(NUM_IN);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] r_buf;
    logic [DEPTH-1:0][DATA_W-1:0] w_buf_next;
    logic [CNT_W-1:0]             r_count;
    logic [CNT_W-1:0]             w_n_req;
    logic [CNT_W-1:0]             w_n_pop;
    logic [CNT_W-1:0]             w_ins_offset;
    logic [CNT_W-1:0]             w_count_next;
    logic                         w_grant_ok;
    logic                         w_wr;

    // Grant only when every requested sample is already buffered; a word
    // arriving this cycle cannot satisfy a request (no bypass).
    assign w_n_req    = CNT_W'(abr_popcount(ABR_MASK_W'(req_i)));
    assign w_grant_ok = rst_b & ~flush & (r_count >= w_n_req);
    assign grant_o    = w_grant_ok ? req_i : '0;
    assign w_n_pop    = w_grant_ok ? w_n_req : '0;

    // Ready looks at the registered count only, so a full buffer must wait
    // one cycle after a pop before accepting again.
    assign data_ready_o = rst_b & ~flush & (r_count <= C_WR_LIMIT);
    assign w_wr         = data_valid_i & data_ready_o;

    // Surviving old samples occupy 0..count-n_pop-1; the new word lands
    // right behind them.
    assign w_ins_offset = r_count - w_n_pop;
    assign w_count_next = w_ins_offset + (w_wr ? C_NUM_IN : '0);

    abr_sample_shifter #(
        .DEPTH   (DEPTH),
        .NUM_INS (NUM_IN),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) u_shifter (
        .i_buf        (r_buf),
        .i_shift      (w_n_pop),
        .i_ins_en     (w_wr),
        .i_ins_offset (w_ins_offset),
        .i_ins_data   (data_i),
        .o_buf        (w_buf_next)
    );

    // Registers only clear at a clock edge, so outputs are forced to zero
    // while reset is asserted to cover the cycle before that edge.
    assign data_o  = rst_b ? r_buf[NUM_OUT-1:0] : '0;
    assign count_o = rst_b ? r_count : '0;

    always_ff @(posedge clk) begin
        if (!rst_b || flush) begin
            r_buf   <= '0;
            r_count <= '0;
        end else begin
            r_buf   <= w_buf_next;
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Interface checks
    // ------------------------------------------------------------------
    logic                          r_stall;
    logic [NUM_IN-1:0][DATA_W-1:0] r_held_data;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_stall     <= 1'b0;
            r_held_data <= '0;
        end else begin
            r_stall     <= data_valid_i & ~data_ready_o & ~flush;
            r_held_data <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            a_req_thermo: assert (abr_is_thermometer(ABR_MASK_W'(req_i)));
            a_count_max:  assert (r_count <= C_DEPTH);
            if (r_stall && data_valid_i) begin
                a_data_stable: assert (data_i == r_held_data);
            end
        end
    end

endmodule : abr_sample_unpacker
`default_nettype wire
